// File: rtl/intra_residue_gen.sv
// intra_residue_gen: forms the intra prediction (vertical / horizontal / DC) for one block
// from latched neighbours and subtracts it from the original block, one row per cycle,
// producing saturated signed 8-bit residue rows for the transform stage.
module intra_residue_gen #(
    parameter int MB_SIZE_L = 4,
    parameter int MB_SIZE_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [2:0]             mode,
    input  logic                   top_avail,
    input  logic                   left_avail,
    input  logic [8*MB_SIZE_W-1:0] toppixels,
    input  logic [8*MB_SIZE_L-1:0] leftpixels,
    input  logic                   orig_valid,
    output logic                   orig_ready,
    input  logic [8*MB_SIZE_W-1:0] orig_row,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [8*MB_SIZE_W-1:0] res_row,
    output logic                   res_last,
    output logic                   busy,
    output logic                   mode_err
);

    localparam int LOG_W = $clog2(MB_SIZE_W);
    localparam int LOG_L = $clog2(MB_SIZE_L);
    localparam int CW    = LOG_L + 1;   // row counters must reach L to close the input side
    localparam int SUM_W = 16;          // wide enough for the sum of all neighbours
    localparam logic [CW-1:0] LAST_ROW = CW'(MB_SIZE_L - 1);
    localparam logic [CW-1:0] ROWS     = CW'(MB_SIZE_L);

    typedef enum logic [1:0] {S_IDLE, S_PRED, S_STREAM} state_t;
    typedef enum logic [1:0] {P_VERT, P_HORZ, P_DC} pred_t;

    state_t        state;
    pred_t         pred_sel;
    logic [2:0]    mode_q;
    logic          top_av_q;
    logic          left_av_q;
    logic [7:0]    top_q  [MB_SIZE_W];
    logic [7:0]    left_q [MB_SIZE_L];
    logic [7:0]    dc_q;
    logic [CW-1:0] rows_in;
    logic [CW-1:0] rows_out;

    logic [SUM_W-1:0]     sum_top;
    logic [SUM_W-1:0]     sum_left;
    logic [7:0]           dc_calc;
    logic                 err_calc;
    logic [7:0]           left_cur;
    logic [7:0]           pix_pred;
    logic [8*MB_SIZE_W-1:0] res_next;
    logic                 in_xfer;
    logic                 out_hs;

    // Difference of two unsigned pixels, clamped to the signed 8-bit residue range.
    function automatic logic [7:0] sat_residue(input logic [7:0] o, input logic [7:0] p);
        logic signed [8:0] d;
        d = $signed({1'b0, o}) - $signed({1'b0, p});
        if (d > 9'sd127)
            return 8'h7f;
        else if (d < -9'sd128)
            return 8'h80;
        else
            return d[7:0];
    endfunction

    assign in_xfer    = orig_valid && orig_ready;
    assign out_hs     = res_valid && res_ready;
    assign orig_ready = (state == S_STREAM) && (rows_in < ROWS) && (!res_valid || res_ready);
    assign busy       = (state != S_IDLE);

    // DC value and fallback decision from the latched neighbours and mode.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        sum_top  = '0;
        sum_left = '0;
        dc_calc  = 8'd128;
        for (int c = 0; c < MB_SIZE_W; c++) sum_top  += SUM_W'(top_q[c]);
        for (int r = 0; r < MB_SIZE_L; r++) sum_left += SUM_W'(left_q[r]);
        if (top_av_q && left_av_q)
            dc_calc = 8'((sum_top + sum_left + SUM_W'(MB_SIZE_W)) >> (LOG_W + 1));
        else if (top_av_q)
            dc_calc = 8'((sum_top + SUM_W'(MB_SIZE_W / 2)) >> LOG_W);
        else if (left_av_q)
            dc_calc = 8'((sum_left + SUM_W'(MB_SIZE_L / 2)) >> LOG_L);
        err_calc = (mode_q > 3'd2)
                || (mode_q == 3'd0 && !top_av_q)
                || (mode_q == 3'd1 && !left_av_q);
    end

    // Residue for the row currently on orig_row, using the prediction chosen in PRED.
    always_comb begin
        res_next = '0;
        pix_pred = '0;
        left_cur = left_q[rows_in[CW-2:0]];
        for (int c = 0; c < MB_SIZE_W; c++) begin
            case (pred_sel)
                P_VERT:  pix_pred = top_q[c];
                P_HORZ:  pix_pred = left_cur;
                default: pix_pred = dc_q;
            endcase
            res_next[8*c +: 8] = sat_residue(orig_row[8*c +: 8], pix_pred);
        end
    end

    // Block FSM, neighbour latches, row counters and the residue output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the neighbour arrays are plain flops rather than a RAM, so they take the
            // synchronous reset together with the rest of the state.
            state     <= S_IDLE;
            pred_sel  <= P_VERT;
            mode_q    <= '0;
            top_av_q  <= 1'b0;
            left_av_q <= 1'b0;
            for (int c = 0; c < MB_SIZE_W; c++) top_q[c]  <= '0;
            for (int r = 0; r < MB_SIZE_L; r++) left_q[r] <= '0;
            dc_q      <= '0;
            rows_in   <= '0;
            rows_out  <= '0;
            mode_err  <= 1'b0;
            res_valid <= 1'b0;
            res_last  <= 1'b0;
            res_row   <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every flop samples
            // the values from before this edge, regardless of statement order.
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_q    <= mode;
                        top_av_q  <= top_avail;
                        left_av_q <= left_avail;
                        for (int c = 0; c < MB_SIZE_W; c++) top_q[c]  <= toppixels[8*c +: 8];
                        for (int r = 0; r < MB_SIZE_L; r++) left_q[r] <= leftpixels[8*r +: 8];
                        mode_err  <= 1'b0;
                        rows_in   <= '0;
                        rows_out  <= '0;
                        state     <= S_PRED;
                    end
                end
                S_PRED: begin
                    dc_q     <= dc_calc;
                    mode_err <= err_calc;
                    if (err_calc || mode_q == 3'd2)
                        pred_sel <= P_DC;
                    else if (mode_q == 3'd0)
                        pred_sel <= P_VERT;
                    else
                        pred_sel <= P_HORZ;
                    state    <= S_STREAM;
                end
                S_STREAM: begin
                    if (in_xfer)
                        rows_in <= rows_in + CW'(1);
                    if (out_hs) begin
                        rows_out <= rows_out + CW'(1);
                        if (rows_out == LAST_ROW)
                            state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // A new row can only arrive when the register is empty or draining this cycle.
            if (in_xfer) begin
                res_row   <= res_next;
                res_valid <= 1'b1;
                res_last  <= (rows_in == LAST_ROW);
            end else if (out_hs) begin
                res_valid <= 1'b0;
                res_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_intra_residue_gen.sv
// tb_intra_residue_gen: runs a 4x4 and an 8x8 instance side by side; each lane issues
// directed and random blocks, pushes model residues into a scoreboard and a monitor
// compares them against every residue handshake.
module tb_intra_residue_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int clamp8(input int d);
        if (d > 127) return 127;
        if (d < -128) return -128;
        return d;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int N = (g == 0) ? 4 : 8;

        logic           reset;
        logic           start;
        logic [2:0]     mode;
        logic           top_avail;
        logic           left_avail;
        logic [8*N-1:0] toppixels;
        logic [8*N-1:0] leftpixels;
        logic           orig_valid;
        logic           orig_ready;
        logic [8*N-1:0] orig_row;
        logic           res_valid;
        logic           res_ready = 1'b0;
        logic [8*N-1:0] res_row;
        logic           res_last;
        logic           busy;
        logic           mode_err;

        intra_residue_gen #(.MB_SIZE_L(N), .MB_SIZE_W(N)) dut (
            .clk        (clk),
            .reset      (reset),
            .start      (start),
            .mode       (mode),
            .top_avail  (top_avail),
            .left_avail (left_avail),
            .toppixels  (toppixels),
            .leftpixels (leftpixels),
            .orig_valid (orig_valid),
            .orig_ready (orig_ready),
            .orig_row   (orig_row),
            .res_valid  (res_valid),
            .res_ready  (res_ready),
            .res_row    (res_row),
            .res_last   (res_last),
            .busy       (busy),
            .mode_err   (mode_err)
        );

        typedef struct {
            logic [8*N-1:0] row;
            bit             last;
            bit             err;
            bit             timed;
            int             edge_no;
        } exp_t;

        exp_t sb[$];
        bit   hold_off    = 1'b1;
        bit   bp_rand     = 1'b0;
        int   stall_until = -1;
        bit   chk_idle    = 1'b0;
        bit   done        = 1'b0;

        function automatic logic [8*N-1:0] pack(input int a[N]);
            logic [8*N-1:0] v;
            for (int c = 0; c < N; c++) v[8*c +: 8] = 8'(a[c]);
            return v;
        endfunction

        // Downstream backpressure: always ready, randomly ready, or a forced stall window.
        always @(posedge clk) begin
            #1;
            if (hold_off)
                res_ready = 1'b0;
            else if (cyc < stall_until)
                res_ready = 1'b0;
            else if (bp_rand)
                res_ready = ($urandom_range(3) != 0);
            else
                res_ready = 1'b1;
        end

        // Monitor: compares each residue handshake with the head of the scoreboard.
        always @(negedge clk) begin : mon
            exp_t e;
            if (chk_idle) begin
                check($sformatf("busy_after_last_n%0d", N), busy, 1'b0);
                chk_idle = 1'b0;
            end
            if (!reset && res_valid && !res_ready)
                check($sformatf("orig_ready_during_stall_n%0d", N), orig_ready, 1'b0);
            if (!reset && res_valid && res_ready) begin
                check($sformatf("row_expected_n%0d", N), sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check($sformatf("res_row_n%0d", N), res_row, e.row);
                    check($sformatf("res_last_n%0d", N), res_last, e.last);
                    check($sformatf("mode_err_n%0d", N), mode_err, e.err);
                    if (e.last) chk_idle = 1'b1;
                    if (e.last && e.timed)
                        check($sformatf("block_latency_n%0d", N), cyc + 1, e.edge_no);
                end
            end
        end

        // One block: model the expected residues, drive start and rows, optionally abort.
        task automatic run_block(input int m, input bit ta, input bit la,
                                 input int top_a[N], input int left_a[N], input int orig_a[N][N],
                                 input bit timed, input bit stall, input bit poke, input int abort_at);
            bit             err;
            bit             use_dc;
            bit             ok;
            int             sum_t;
            int             sum_l;
            int             dc;
            int             p;
            int             start_edge;
            logic [8*N-1:0] exp_row;
            exp_t           e;
            err    = (m > 2) || (m == 0 && !ta) || (m == 1 && !la);
            use_dc = err || (m == 2);
            sum_t  = 0;
            sum_l  = 0;
            for (int i = 0; i < N; i++) begin
                sum_t += top_a[i];
                sum_l += left_a[i];
            end
            if (ta && la)  dc = (sum_t + sum_l + N) / (2 * N);
            else if (ta)   dc = (sum_t + N / 2) / N;
            else if (la)   dc = (sum_l + N / 2) / N;
            else           dc = 128;

            start      = 1'b1;
            mode       = 3'(m);
            top_avail  = ta;
            left_avail = la;
            toppixels  = pack(top_a);
            leftpixels = pack(left_a);
            start_edge = cyc + 1;
            @(posedge clk); #1;
            start = 1'b0;
            for (int c = 0; c < N; c++) begin
                toppixels[8*c +: 8]  = 8'($urandom);
                leftpixels[8*c +: 8] = 8'($urandom);
            end

            for (int r = 0; r < abort_at; r++) begin
                if (bp_rand && $urandom_range(3) == 0) begin
                    orig_valid = 1'b0;
                    repeat ($urandom_range(2) + 1) @(posedge clk);
                    #1;
                end
                for (int c = 0; c < N; c++) begin
                    p = use_dc ? dc : ((m == 0) ? top_a[c] : left_a[r]);
                    exp_row[8*c +: 8] = 8'(clamp8(orig_a[r][c] - p));
                end
                e.row     = exp_row;
                e.last    = (r == N - 1);
                e.err     = err;
                e.timed   = timed;
                e.edge_no = start_edge + N + 2;
                sb.push_back(e);
                orig_valid = 1'b1;
                for (int c = 0; c < N; c++) orig_row[8*c +: 8] = 8'(orig_a[r][c]);
                ok = 1'b0;
                for (int k = 0; k < 200 && !ok; k++) begin
                    @(negedge clk);
                    ok = orig_ready;
                    @(posedge clk); #1;
                end
                check($sformatf("orig_handshake_n%0d", N), ok, 1'b1);
                orig_valid = 1'b0;
                if (poke && r == 0) begin
                    start     = 1'b1;
                    mode      = ~mode;
                    top_avail = !ta;
                end
                if (poke && r == 1) start = 1'b0;
                if (stall && r == 1) stall_until = cyc + 3;
            end

            if (abort_at < N) begin
                hold_off = 1'b1;
                @(posedge clk); #1;
                @(posedge clk); #1;
                reset = 1'b1;
                sb.delete();
                @(posedge clk); #1;
                reset    = 1'b0;
                hold_off = 1'b0;
                @(negedge clk);
                check($sformatf("busy_after_reset_n%0d", N), busy, 1'b0);
                check($sformatf("res_valid_after_reset_n%0d", N), res_valid, 1'b0);
                check($sformatf("mode_err_after_reset_n%0d", N), mode_err, 1'b0);
                @(posedge clk); #1;
            end else begin
                ok = 1'b0;
                for (int k = 0; k < 2000 && !ok; k++) begin
                    @(negedge clk);
                    ok = (sb.size() == 0) && !busy;
                end
                check($sformatf("block_done_n%0d", N), ok, 1'b1);
                check($sformatf("mode_err_held_n%0d", N), mode_err, err);
                @(posedge clk); #1;
            end
        endtask

        initial begin : stim
            int  t[N];
            int  l[N];
            int  o[N][N];
            int  m;
            bit  ext;
            reset      = 1'b1;
            start      = 1'b0;
            mode       = '0;
            top_avail  = 1'b0;
            left_avail = 1'b0;
            toppixels  = '0;
            leftpixels = '0;
            orig_valid = 1'b0;
            orig_row   = '0;
            repeat (3) @(posedge clk);
            #1;
            reset    = 1'b0;
            hold_off = 1'b0;
            @(negedge clk);
            check($sformatf("rst_busy_n%0d", N), busy, 1'b0);
            check($sformatf("rst_res_valid_n%0d", N), res_valid, 1'b0);
            check($sformatf("rst_res_last_n%0d", N), res_last, 1'b0);
            check($sformatf("rst_mode_err_n%0d", N), mode_err, 1'b0);
            check($sformatf("rst_orig_ready_n%0d", N), orig_ready, 1'b0);
            check($sformatf("rst_res_row_n%0d", N), res_row, '0);
            @(posedge clk); #1;

            // Vertical with a ramp on top, flat original.
            for (int i = 0; i < N; i++) begin t[i] = 10 * (i + 1); l[i] = $urandom_range(255); end
            for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) o[r][c] = 50;
            run_block(0, 1, 1, t, l, o, 1, 0, 0, N);

            // DC with both neighbours, residue exactly zero.
            for (int i = 0; i < N; i++) begin t[i] = 100; l[i] = 104; end
            for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) o[r][c] = 102;
            run_block(2, 1, 1, t, l, o, 1, 0, 0, N);

            // Horizontal saturating low, then high.
            for (int i = 0; i < N; i++) l[i] = 255;
            for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) o[r][c] = 0;
            run_block(1, 0, 1, t, l, o, 1, 0, 0, N);
            for (int i = 0; i < N; i++) l[i] = 0;
            for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) o[r][c] = 255;
            run_block(1, 0, 1, t, l, o, 1, 0, 0, N);

            // Vertical with no neighbours: falls back to 128 and flags mode_err.
            for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) o[r][c] = 128;
            run_block(0, 0, 0, t, l, o, 1, 0, 0, N);

            // Mid-block backpressure, then an ignored start while streaming.
            for (int i = 0; i < N; i++) begin t[i] = $urandom_range(255); l[i] = $urandom_range(255); end
            for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) o[r][c] = $urandom_range(255);
            run_block(0, 1, 1, t, l, o, 0, 1, 0, N);
            run_block(1, 1, 1, t, l, o, 1, 0, 1, N);

            // Reset at row 2, then a full block after it.
            run_block(1, 1, 1, t, l, o, 0, 0, 0, 2);
            run_block(2, 1, 0, t, l, o, 1, 0, 0, N);

            // Random blocks, alternating free-flowing and randomly throttled handshakes.
            for (int b = 0; b < 14; b++) begin
                bp_rand = b[0];
                m   = ($urandom_range(3) == 0) ? int'($urandom_range(7, 3)) : int'($urandom_range(2));
                ext = ($urandom_range(2) == 0);
                for (int i = 0; i < N; i++) begin t[i] = $urandom_range(255); l[i] = $urandom_range(255); end
                for (int r = 0; r < N; r++)
                    for (int c = 0; c < N; c++)
                        o[r][c] = ext ? ($urandom_range(1) ? 255 : 0) : int'($urandom_range(255));
                run_block(m, $urandom_range(1) == 1, $urandom_range(1) == 1, t, l, o, !bp_rand, 0, 0, N);
            end
            bp_rand = 1'b0;
            done    = 1'b1;
        end
    end

    initial begin
        for (int i = 0; i < 60000 && !(lane[0].done && lane[1].done); i++) @(posedge clk);
        check("lanes_finished", {lane[0].done, lane[1].done}, 2'b11);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
